// File: rtl/ud_counter_gen.sv
// ud_counter_gen: parametrised up/down counter with programmable step and
// inclusive upper limit, wrap-around or saturation at the bounds, parallel
// load, a registered terminal-count pulse and sticky overflow/underflow flags.
// Intended as a generic event/address counter for timers, pointer generation
// and rate dividers.
//
// Parameters
//   WIDTH   counter, load_data and limit width (>= 2)
//   STEP_W  step input width (1..WIDTH)
//   WRAP    1 = wrap modulo (limit+1) at the bounds, 0 = saturate at 0/limit
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-low
//   en         count enable
//   load       parallel load strobe (beats en)
//   load_data  value to load, clamped to limit
//   up_dn      1 = count up, 0 = count down
//   step       increment/decrement magnitude
//   limit      inclusive upper bound; legal count range is 0..limit
//   clr_flags  clears ovf/unf on the next edge (a new crossing wins)
//   count      registered count value
//   tc         registered one-cycle terminal-count pulse
//   ovf        sticky: an up-count crossed limit
//   unf        sticky: a down-count crossed 0
//   at_max     count == limit (combinational)
//   at_min     count == 0 (combinational)
module ud_counter_gen #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned WRAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              up_dn,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_min
);

  // One extra bit so that limit+1 and count+step never overflow.
  localparam int unsigned XW = WIDTH + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [XW-1:0] limit_x;   // limit, widened
  logic [XW-1:0] range_x;   // limit + 1, the modulus in wrap mode
  logic [XW-1:0] step_x;
  logic [XW-1:0] step_eff;  // min(step, limit+1)
  logic [XW-1:0] count_x;
  logic [XW-1:0] sum_up;    // count + step_eff
  logic [XW-1:0] wrap_up;   // sum_up - (limit+1)
  logic [XW-1:0] diff_dn;   // count - step_eff, valid when no underflow
  logic [XW-1:0] wrap_dn;   // count + (limit+1) - step_eff
  logic [XW-1:0] next_x;    // next count; top bit is always 0

  logic cross_up;
  logic cross_dn;
  logic out_of_range;
  logic unused_next;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  assign limit_x  = {1'b0, limit};
  assign range_x  = limit_x + XW'(1);
  assign step_x   = XW'(step);
  assign step_eff = (step_x > range_x) ? range_x : step_x;
  assign count_x  = {1'b0, count_q};

  assign sum_up  = count_x + step_eff;
  assign wrap_up = sum_up - range_x;
  assign diff_dn = count_x - step_eff;
  assign wrap_dn = count_x + range_x - step_eff;

  // With step_eff == 0 neither condition can be true, so a zero step never
  // pulses tc or touches the flags. limit == 0 forces step_eff to 0 or 1.
  assign cross_up = sum_up > limit_x;
  assign cross_dn = count_x < step_eff;

  // Count can exceed limit only when limit is lowered while counting.
  assign out_of_range = count_q > limit;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_x = count_x;
    tc_d   = 1'b0;
    ovf_d  = ovf_q & ~clr_flags;
    unf_d  = unf_q & ~clr_flags;

    if (load) begin
      next_x = (load_data > limit) ? limit_x : {1'b0, load_data};
    end else if (out_of_range) begin
      // Pull back into range first; the enable is ignored this cycle.
      next_x = limit_x;
    end else if (en) begin
      if (up_dn) begin
        if (cross_up) begin
          tc_d   = 1'b1;
          ovf_d  = 1'b1;
          next_x = (WRAP != 0) ? wrap_up : limit_x;
        end else begin
          next_x = sum_up;
        end
      end else begin
        if (cross_dn) begin
          tc_d   = 1'b1;
          unf_d  = 1'b1;
          next_x = (WRAP != 0) ? wrap_dn : '0;
        end else begin
          next_x = diff_dn;
        end
      end
    end
  end

  assign count_d     = next_x[WIDTH-1:0];
  assign unused_next = next_x[WIDTH];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count  = count_q;
  assign tc     = tc_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = (count_q == limit);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_ud_counter_gen.sv
// Bench for ud_counter_gen: one wrapping and one saturating instance share the
// same stimulus. A behavioural model (plain integer arithmetic) is compared to
// both on every falling edge; directed checks pin literal values.
module tb_ud_counter_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_data;
  logic       up_dn;
  logic [3:0] step;
  logic [7:0] limit;
  logic       clr_flags;

  logic [7:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ovf_w, ovf_s, unf_w, unf_s;
  logic       amax_w, amax_s, amin_w, amin_s;

  int total;
  int bad;
  bit checking;

  // Model state, index 0 = saturating, 1 = wrapping.
  int m_count [2];
  int m_tc    [2];
  int m_ovf   [2];
  int m_unf   [2];

  ud_counter_gen #(.WIDTH(8), .STEP_W(4), .WRAP(1)) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_data (load_data),
    .up_dn     (up_dn),
    .step      (step),
    .limit     (limit),
    .clr_flags (clr_flags),
    .count     (cnt_w),
    .tc        (tc_w),
    .ovf       (ovf_w),
    .unf       (unf_w),
    .at_max    (amax_w),
    .at_min    (amin_w)
  );

  ud_counter_gen #(.WIDTH(8), .STEP_W(4), .WRAP(0)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_data (load_data),
    .up_dn     (up_dn),
    .step      (step),
    .limit     (limit),
    .clr_flags (clr_flags),
    .count     (cnt_s),
    .tc        (tc_s),
    .ovf       (ovf_s),
    .unf       (unf_s),
    .at_max    (amax_s),
    .at_min    (amin_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the counter lives on the integer ring 0..limit.
  always @(posedge clk) begin : model
    int c, lim, m, se, s, cu, cd;
    for (int w = 0; w < 2; w++) begin
      c   = m_count[w];
      lim = int'(limit);
      m   = lim + 1;
      cu  = 0;
      cd  = 0;
      if (!rst) begin
        m_count[w] <= 0;
        m_tc[w]    <= 0;
        m_ovf[w]   <= 0;
        m_unf[w]   <= 0;
      end else begin
        if (load) begin
          c = (int'(load_data) > lim) ? lim : int'(load_data);
        end else if (c > lim) begin
          c = lim;
        end else if (en) begin
          se = (int'(step) < m) ? int'(step) : m;
          if (up_dn) begin
            s = c + se;
            if (s > lim) cu = 1;
            c = cu ? ((w == 1) ? s % m : lim) : s;
          end else begin
            s = c - se;
            if (s < 0) cd = 1;
            c = cd ? ((w == 1) ? ((s % m) + m) % m : 0) : s;
          end
        end
        m_count[w] <= c;
        m_tc[w]    <= cu | cd;
        m_ovf[w]   <= ((m_ovf[w] != 0) && !clr_flags) || (cu != 0) ? 1 : 0;
        m_unf[w]   <= ((m_unf[w] != 0) && !clr_flags) || (cd != 0) ? 1 : 0;
      end
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("model_count_wrap", int'(cnt_w), m_count[1]);
      chk("model_tc_wrap", int'(tc_w), m_tc[1]);
      chk("model_ovf_wrap", int'(ovf_w), m_ovf[1]);
      chk("model_unf_wrap", int'(unf_w), m_unf[1]);
      chk("model_atmax_wrap", int'(amax_w), (m_count[1] == int'(limit)) ? 1 : 0);
      chk("model_atmin_wrap", int'(amin_w), (m_count[1] == 0) ? 1 : 0);
      chk("model_count_sat", int'(cnt_s), m_count[0]);
      chk("model_tc_sat", int'(tc_s), m_tc[0]);
      chk("model_ovf_sat", int'(ovf_s), m_ovf[0]);
      chk("model_unf_sat", int'(unf_s), m_unf[0]);
      chk("model_atmax_sat", int'(amax_s), (m_count[0] == int'(limit)) ? 1 : 0);
      chk("model_atmin_sat", int'(amin_s), (m_count[0] == 0) ? 1 : 0);
    end
  end

  // Inputs change 2 time units after the rising edge; outputs are stable then.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    checking  = 1'b0;
    rst       = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    load_data = '0;
    up_dn     = 1'b1;
    step      = '0;
    limit     = 8'd255;
    clr_flags = 1'b0;
    tick();
    checking = 1'b1;
    tick();
    rst = 1'b1;

    // 1: reset mid-count, load alongside reset is ignored
    load = 1'b1; load_data = 8'h37;
    tick();
    chk("load_37_wrap", int'(cnt_w), 8'h37);
    chk("load_37_sat", int'(cnt_s), 8'h37);
    rst = 1'b0; load_data = 8'h11;
    tick();
    tick();
    chk("rst_count", int'(cnt_w), 0);
    chk("rst_tc", int'(tc_w), 0);
    chk("rst_ovf", int'(ovf_s), 0);
    chk("rst_unf", int'(unf_s), 0);
    rst = 1'b1; load = 1'b0;

    // 2: up past limit=9 with step 3 from 8
    limit = 8'd9; load = 1'b1; load_data = 8'd8;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; step = 4'd3;
    tick();
    chk("wrap_up_count", int'(cnt_w), 1);
    chk("wrap_up_tc", int'(tc_w), 1);
    chk("wrap_up_ovf", int'(ovf_w), 1);
    chk("sat_up_count", int'(cnt_s), 9);
    chk("sat_up_tc", int'(tc_s), 1);
    tick();
    chk("wrap_up2_count", int'(cnt_w), 4);
    chk("wrap_up2_tc", int'(tc_w), 0);
    chk("wrap_up2_ovf", int'(ovf_w), 1);
    chk("sat_up2_tc", int'(tc_s), 1);

    // 3: down past 0 with step 4 from 2
    en = 1'b0; load = 1'b1; load_data = 8'd2; step = 4'd4;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    chk("wrap_dn_count", int'(cnt_w), 8);
    chk("wrap_dn_unf", int'(unf_w), 1);
    chk("wrap_dn_tc", int'(tc_w), 1);
    chk("sat_dn_count", int'(cnt_s), 0);
    chk("sat_dn_tc", int'(tc_s), 1);
    tick();
    chk("wrap_dn2_count", int'(cnt_w), 4);
    chk("wrap_dn2_tc", int'(tc_w), 0);
    chk("sat_dn2_tc", int'(tc_s), 1);
    en = 1'b0;

    // 4: load clamp, load beats en
    limit = 8'd100; load = 1'b1; load_data = 8'd200;
    tick();
    chk("clamp_count", int'(cnt_w), 100);
    chk("clamp_atmax", int'(amax_w), 1);
    chk("clamp_tc", int'(tc_s), 0);
    load_data = 8'd5; en = 1'b1; up_dn = 1'b1; step = 4'd3;
    tick();
    chk("load_beats_en", int'(cnt_s), 5);
    en = 1'b0;

    // 5: lowering the limit live, then a zero step
    load_data = 8'd50;
    tick();
    load = 1'b0; limit = 8'd20; en = 1'b1;
    tick();
    chk("fix_count", int'(cnt_w), 20);
    chk("fix_tc", int'(tc_w), 0);
    step = 4'd0;
    tick();
    chk("step0_count", int'(cnt_s), 20);
    chk("step0_tc", int'(tc_s), 0);
    chk("step0_atmax", int'(amax_s), 1);

    // 6: flag clearing versus a simultaneous crossing, limit == 0
    step = 4'd1; clr_flags = 1'b1;
    tick();
    chk("clr_vs_cross_ovf", int'(ovf_w), 1);
    chk("clr_vs_cross_tc", int'(tc_s), 1);
    en = 1'b0;
    tick();
    chk("clr_ovf", int'(ovf_w), 0);
    chk("clr_unf", int'(unf_s), 0);
    clr_flags = 1'b0; limit = 8'd0; load = 1'b1; load_data = 8'd0;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("lim0_up_count", int'(cnt_s), 0);
    chk("lim0_up_tc", int'(tc_w), 1);
    chk("lim0_up_ovf", int'(ovf_s), 1);
    up_dn = 1'b0;
    tick();
    chk("lim0_dn_unf", int'(unf_w), 1);
    chk("lim0_dn_tc", int'(tc_s), 1);
    en = 1'b0;
    tick();
    chk("lim0_idle_tc", int'(tc_w), 0);

    // Mixed directed sweep, checked by the model only
    for (int i = 0; i < 60; i++) begin
      limit     = (i < 30) ? 8'd12 : 8'd5;
      step      = 4'(i % 7);
      up_dn     = ((i / 4) % 2) == 0;
      en        = (i % 5) != 0;
      load      = (i % 11) == 3;
      load_data = 8'(i * 9);
      clr_flags = (i % 13) == 7;
      rst       = (i != 45);
      tick();
    end
    rst = 1'b1; en = 1'b0; load = 1'b0; clr_flags = 1'b0;
    tick();
    checking = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
